read_intr_scheduler: RTL and testbench
======================================

READ_INTR_SCHEDULER -- requirements
Module: read_intr_scheduler

Interface
- REQ-001 Parameter NUM_CH, default 4: number of requesting data channels.
- REQ-002 Parameter CH_WIDTH, default 2: channel index width; CH_WIDTH SHALL satisfy 2^CH_WIDTH >= NUM_CH.
- REQ-003 Parameter TIMEOUT, default 1000: maximum cycles spent waiting for read_done.
- REQ-004 Parameter GAP_CYCLES, default 10: idle spacing after each service.
- REQ-005 Parameter CNT_WIDTH, default 15: width of the timeout and gap counters.
- REQ-006 clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
- REQ-007 rst_n  input  1: reset, asynchronous and active-low.
- REQ-008 en  input  1: scheduler enable; low blocks new grants only.
- REQ-009 req  input  NUM_CH: per-channel level request ("data ready"), held until acknowledged.
- REQ-010 read_done  input  1: one-cycle pulse from PS software when the current channel has been read.
- REQ-011 read_start_intr  output  1: one-cycle pulse that starts the interrupt generator.
- REQ-012 cur_ch  output  CH_WIDTH: index of the channel being serviced, for PS readback.
- REQ-013 busy  output  1: high in every state except IDLE.
- REQ-014 ack  output  NUM_CH: one-hot, one-cycle pulse to the serviced channel on completion.
- REQ-015 timeout  output  1: one-cycle pulse when a wait expires.
- REQ-016 err_cnt  output  8: saturating count of timeouts.

Function
- REQ-017 All outputs SHALL be registered.
- REQ-018 The FSM SHALL have states IDLE, WAIT and GAP; any illegal encoding SHALL return to IDLE with outputs cleared.
- REQ-019 IDLE: when en=1 and req!=0, the block SHALL grant the winner, load cur_ch, pulse read_start_intr, clear the timeout counter, and enter WAIT.
- REQ-020 Arbitration SHALL be round-robin: search starts at last_ch+1 modulo NUM_CH, where last_ch is the most recently serviced channel (reset value NUM_CH-1, so channel 0 has first priority).
- REQ-021 Latency: req seen in cycle n SHALL give read_start_intr=1 and a valid cur_ch in cycle n+1.
- REQ-022 WAIT with read_done=1: ack[cur_ch] SHALL pulse, last_ch SHALL be set to cur_ch, and the FSM SHALL enter GAP.
- REQ-023 WAIT without read_done: the counter SHALL increment.
  - When the counter reaches TIMEOUT-1 (TIMEOUT cycles in WAIT), timeout SHALL pulse, err_cnt SHALL increment (saturating at 255), last_ch SHALL be set to cur_ch, and the FSM SHALL enter GAP.
  - ack SHALL NOT pulse on timeout.
- REQ-024 If read_done and timeout expiry occur in the same cycle, read_done SHALL take priority: ack pulses, no timeout pulse, err_cnt unchanged.
- REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; no grant SHALL be issued during GAP.
- REQ-026 read_done in IDLE or GAP SHALL be ignored.
- REQ-027 Changes on req while in WAIT or GAP SHALL not affect cur_ch.
- REQ-028 en=0 SHALL only block grants in IDLE; a service already in progress SHALL complete normally.
- REQ-029 cur_ch SHALL hold its value after completion until the next grant.

Reset
- REQ-030 While rst_n=0, asynchronously:
  - state SHALL be IDLE.
  - read_start_intr, busy, ack and timeout SHALL be 0.
  - cur_ch, the counters and err_cnt SHALL be 0.
  - last_ch SHALL be NUM_CH-1.
- REQ-031 Reset asserted mid-WAIT or mid-GAP SHALL abort the service with no ack or timeout pulse.
- REQ-032 The first grant after reset release SHALL follow REQ-021.

Verification (NUM_CH=4, TIMEOUT=100, GAP_CYCLES=10)
- REQ-033 req=4'b0110 held, read_done 5 cycles after each start: grants SHALL be ch1, ch2, ch1, ch2, with each read_start_intr exactly 1 cycle.
- REQ-034 req=4'b0001, no read_done: timeout SHALL pulse 100 cycles after the start pulse with no ack pulse; err_cnt SHALL reach 1; the next start SHALL occur 10 cycles after GAP entry plus 1 cycle.
- REQ-035 read_done on the same cycle as timeout expiry: ack=4'b0001 SHALL pulse, timeout SHALL stay 0 and err_cnt SHALL be unchanged.
- REQ-036 Hold req=4'b1000 with no read_done for 300 timeouts: err_cnt SHALL saturate at 255.
- REQ-037 en=0 during WAIT: the current service SHALL complete with ack; with req still pending, no new start SHALL occur until en=1.
- REQ-038 rst_n pulsed low mid-WAIT: outputs SHALL clear immediately without waiting for a clock edge; after release, req=4'b1111 SHALL grant ch0 first.

Source files
------------

// File: rtl/read_intr_scheduler.sv
// Round-robin read scheduler: grants one data channel at a time, starts the
// interrupt generator, waits for PS read_done (with timeout), then idles for a gap.
module read_intr_scheduler #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned CH_WIDTH   = 2,
   parameter int unsigned TIMEOUT    = 1000,
   parameter int unsigned GAP_CYCLES = 10,
   parameter int unsigned CNT_WIDTH  = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [NUM_CH-1:0]   req,
   input  logic                read_done,
   output logic                read_start_intr,
   output logic [CH_WIDTH-1:0] cur_ch,
   output logic                busy,
   output logic [NUM_CH-1:0]   ack,
   output logic                timeout,
   output logic [7:0]          err_cnt
);

   localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [CH_WIDTH-1:0]  LAST_RST = CH_WIDTH'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CH_WIDTH-1:0]  last_ch;
   logic                 grant_valid;
   logic [CH_WIDTH-1:0]  grant_ch;

   // Round-robin search starting just after the most recently serviced channel
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!grant_valid && req[(32'(last_ch) + i + 1) % NUM_CH]) begin
            grant_valid = 1'b1;
            grant_ch    = CH_WIDTH'((32'(last_ch) + i + 1) % NUM_CH);
         end
      end
   end

   // Scheduler FSM; all outputs registered, pulses default low each cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         last_ch         <= LAST_RST;
         read_start_intr <= 1'b0;
         cur_ch          <= '0;
         busy            <= 1'b0;
         ack             <= '0;
         timeout         <= 1'b0;
         err_cnt         <= '0;
      end else begin
         read_start_intr <= 1'b0;
         ack             <= '0;
         timeout         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en && grant_valid) begin
                  state           <= ST_WAIT;
                  cur_ch          <= grant_ch;
                  read_start_intr <= 1'b1;
                  busy            <= 1'b1;
                  cnt             <= '0;
               end
            end
            ST_WAIT: begin
               // read_done wins over a coincident timeout expiry
               if (read_done) begin
                  ack     <= NUM_CH'(1) << cur_ch;
                  last_ch <= cur_ch;
                  state   <= ST_GAP;
                  cnt     <= '0;
               end else if (cnt == TO_LAST) begin
                  timeout <= 1'b1;
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  last_ch <= cur_ch;
                  state   <= ST_GAP;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_WIDTH'(1);
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_WIDTH'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy   <= 1'b0;
               cnt    <= '0;
               cur_ch <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_read_intr_scheduler.sv
// Bench for read_intr_scheduler: expected grants queued from a round-robin model,
// popped when the DUT issues read_start_intr.
module tb_read_intr_scheduler;
   localparam int NUM_CH = 4;
   localparam int CH_WIDTH = 2;
   localparam int TIMEOUT = 100;
   localparam int GAP_CYCLES = 10;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                en = 1'b0;
   logic [NUM_CH-1:0]   req = '0;
   logic                read_done = 1'b0;
   logic                read_start_intr;
   logic [CH_WIDTH-1:0] cur_ch;
   logic                busy;
   logic [NUM_CH-1:0]   ack;
   logic                timeout;
   logic [7:0]          err_cnt;

   int n_checks = 0;
   int n_fail = 0;
   int exp_q[$];
   int m_last = NUM_CH - 1;
   int m_err = 0;

   read_intr_scheduler #(
      .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .TIMEOUT(TIMEOUT),
      .GAP_CYCLES(GAP_CYCLES), .CNT_WIDTH(15)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .read_done(read_done),
      .read_start_intr(read_start_intr), .cur_ch(cur_ch), .busy(busy),
      .ack(ack), .timeout(timeout), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic int rr_pick(input logic [NUM_CH-1:0] r, input int last);
      for (int i = 1; i <= NUM_CH; i++) begin
         int c = (last + i) % NUM_CH;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   task automatic wait_start(input int max_cyc, output bit got, output int cyc);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (read_start_intr === 1'b1) got = 1'b1;
      end
   endtask

   task automatic wait_timeout(input int max_cyc, output bit got, output int cyc, output bit saw_ack);
      got = 1'b0;
      cyc = 0;
      saw_ack = 1'b0;
      while (!got && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (ack !== '0) saw_ack = 1'b1;
         if (timeout === 1'b1) got = 1'b1;
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = '0;
      en = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (read_start_intr !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%b exp=0", read_start_intr); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack got=%b exp=0000", ack); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
      n_checks++; if (cur_ch !== 2'd0) begin n_fail++; $display("FAIL rst_cur_ch got=%0d exp=0", cur_ch); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_busy got=%b exp=0", busy); end
   endtask

   task automatic test_round_robin();
      bit got; int cyc; int exp; bit ok;
      en = 1'b1;
      req = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(rr_pick(req, m_last));
         wait_start(40, got, cyc);
         n_checks++;
         if (!got) begin n_fail++; $display("FAIL rr_start_seen got=0 exp=1 (grant %0d)", k); exp_q.delete(); return; end
         exp = exp_q.pop_front();
         n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL rr_cur_ch got=%0d exp=%0d", cur_ch, exp); end
         @(negedge clk);
         n_checks++; if (read_start_intr !== 1'b0) begin n_fail++; $display("FAIL rr_start_width got=%b exp=0", read_start_intr); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy got=%b exp=1", busy); end
         repeat (4) @(negedge clk);
         read_done = 1'b1;
         @(negedge clk);
         read_done = 1'b0;
         n_checks++; if (ack !== NUM_CH'(1 << exp)) begin n_fail++; $display("FAIL rr_ack got=%b exp=%b", ack, NUM_CH'(1 << exp)); end
         n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rr_timeout got=%b exp=0", timeout); end
         m_last = exp;
         if (k == 3) req = '0;
      end
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_idle got=busy exp=idle"); end
      n_checks++; if (cur_ch !== CH_WIDTH'(m_last)) begin n_fail++; $display("FAIL rr_cur_ch_hold got=%0d exp=%0d", cur_ch, m_last); end
   endtask

   task automatic test_timeout();
      bit got; int cyc; int exp; bit saw_ack; bit ok;
      req = 4'b0001;
      exp_q.push_back(rr_pick(req, m_last));
      wait_start(40, got, cyc);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL to_start_seen got=0 exp=1"); exp_q.delete(); return; end
      exp = exp_q.pop_front();
      n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL to_cur_ch got=%0d exp=%0d", cur_ch, exp); end
      wait_timeout(150, got, cyc, saw_ack);
      n_checks++; if (!got || cyc != TIMEOUT) begin n_fail++; $display("FAIL to_latency got=%0d seen=%b exp=%0d", cyc, got, TIMEOUT); end
      n_checks++; if (saw_ack) begin n_fail++; $display("FAIL to_no_ack got=ack_pulse exp=none"); end
      m_err = sat_inc(m_err);
      m_last = exp;
      n_checks++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL to_err_cnt got=%0d exp=%0d", err_cnt, m_err); end
      exp_q.push_back(rr_pick(req, m_last));
      wait_start(40, got, cyc);
      n_checks++; if (!got || cyc != GAP_CYCLES + 1) begin n_fail++; $display("FAIL to_gap_restart got=%0d seen=%b exp=%0d", cyc, got, GAP_CYCLES + 1); end
      exp = exp_q.pop_front();
      n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL to_regrant_ch got=%0d exp=%0d", cur_ch, exp); end
      // read_done lands on the very cycle the wait would expire
      repeat (TIMEOUT - 1) @(negedge clk);
      read_done = 1'b1;
      @(negedge clk);
      read_done = 1'b0;
      n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL expiry_ack got=%b exp=0001", ack); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL expiry_timeout got=%b exp=0", timeout); end
      n_checks++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL expiry_err_cnt got=%0d exp=%0d", err_cnt, m_err); end
      m_last = exp;
      req = '0;
      @(negedge clk);
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL expiry_late_timeout got=%b exp=0", timeout); end
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL to_idle got=busy exp=idle"); end
   endtask

   task automatic test_saturation();
      bit got; int cyc; int exp; bit saw_ack; bit ok;
      req = 4'b1000;
      for (int k = 0; k < 300; k++) begin
         exp_q.push_back(rr_pick(req, m_last));
         wait_start(200, got, cyc);
         n_checks++;
         if (!got) begin n_fail++; $display("FAIL sat_start_seen got=0 exp=1 (iter %0d)", k); exp_q.delete(); req = '0; return; end
         exp = exp_q.pop_front();
         n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL sat_cur_ch got=%0d exp=%0d", cur_ch, exp); end
         wait_timeout(150, got, cyc, saw_ack);
         n_checks++; if (!got || saw_ack) begin n_fail++; $display("FAIL sat_timeout seen=%b ack_seen=%b exp=1/0", got, saw_ack); end
         m_err = sat_inc(m_err);
         m_last = exp;
         n_checks++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL sat_err_cnt got=%0d exp=%0d", err_cnt, m_err); end
      end
      n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_final got=%0d exp=255", err_cnt); end
      req = '0;
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_idle got=busy exp=idle"); end
   endtask

   task automatic test_en_block();
      bit got; int cyc; int exp; bit ok; bit saw_start;
      en = 1'b1;
      req = 4'b0010;
      exp_q.push_back(rr_pick(req, m_last));
      wait_start(40, got, cyc);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL en_start_seen got=0 exp=1"); exp_q.delete(); return; end
      exp = exp_q.pop_front();
      n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL en_cur_ch got=%0d exp=%0d", cur_ch, exp); end
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      read_done = 1'b1;
      @(negedge clk);
      read_done = 1'b0;
      n_checks++; if (ack !== NUM_CH'(1 << exp)) begin n_fail++; $display("FAIL en_ack got=%b exp=%b", ack, NUM_CH'(1 << exp)); end
      m_last = exp;
      saw_start = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (read_start_intr !== 1'b0) saw_start = 1'b1;
      end
      n_checks++; if (saw_start) begin n_fail++; $display("FAIL en_blocked got=start exp=none"); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_idle_busy got=%b exp=0", busy); end
      en = 1'b1;
      exp_q.push_back(rr_pick(req, m_last));
      wait_start(5, got, cyc);
      n_checks++; if (!got || cyc != 1) begin n_fail++; $display("FAIL en_resume_latency got=%0d seen=%b exp=1", cyc, got); end
      exp = exp_q.pop_front();
      n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL en_resume_ch got=%0d exp=%0d", cur_ch, exp); end
      repeat (2) @(negedge clk);
      req = '0;
      read_done = 1'b1;
      @(negedge clk);
      read_done = 1'b0;
      n_checks++; if (ack !== NUM_CH'(1 << exp)) begin n_fail++; $display("FAIL en_resume_ack got=%b exp=%b", ack, NUM_CH'(1 << exp)); end
      m_last = exp;
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL en_idle got=busy exp=idle"); end
   endtask

   task automatic test_reset_mid();
      bit got; int cyc; int exp; bit ok; bit saw_pulse;
      en = 1'b1;
      req = 4'b0100;
      exp_q.push_back(rr_pick(req, m_last));
      wait_start(40, got, cyc);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL rm_start_seen got=0 exp=1"); exp_q.delete(); return; end
      exp = exp_q.pop_front();
      n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL rm_cur_ch got=%0d exp=%0d", cur_ch, exp); end
      repeat (3) @(negedge clk);
      // drop reset between edges: outputs must clear without a clock
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got=%b exp=0", busy); end
      n_checks++; if (cur_ch !== 2'd0) begin n_fail++; $display("FAIL rm_cur_ch_clr got=%0d exp=0", cur_ch); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_err_cnt got=%0d exp=0", err_cnt); end
      n_checks++; if (read_start_intr !== 1'b0 || ack !== 4'b0000 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL rm_pulses got=%b/%b/%b exp=0/0000/0", read_start_intr, ack, timeout); end
      m_last = NUM_CH - 1;
      m_err = 0;
      exp_q.delete();
      req = 4'b1111;
      saw_pulse = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ack !== '0 || timeout !== 1'b0 || read_start_intr !== 1'b0) saw_pulse = 1'b1;
      end
      n_checks++; if (saw_pulse) begin n_fail++; $display("FAIL rm_held_quiet got=pulse exp=none"); end
      rst_n = 1'b1;
      exp_q.push_back(rr_pick(req, m_last));
      @(negedge clk);
      n_checks++; if (read_start_intr !== 1'b1) begin n_fail++; $display("FAIL rm_first_grant_latency got=%b exp=1", read_start_intr); end
      exp = exp_q.pop_front();
      n_checks++; if (cur_ch !== CH_WIDTH'(exp)) begin n_fail++; $display("FAIL rm_first_grant_ch got=%0d exp=%0d", cur_ch, exp); end
      repeat (2) @(negedge clk);
      req = '0;
      read_done = 1'b1;
      @(negedge clk);
      read_done = 1'b0;
      n_checks++; if (ack !== NUM_CH'(1 << exp)) begin n_fail++; $display("FAIL rm_ack got=%b exp=%b", ack, NUM_CH'(1 << exp)); end
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_idle got=busy exp=idle"); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_timeout();
      test_saturation();
      test_en_block();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
